// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared types and constants for the PS/2 set-2 key mapper.
//   dir_t        - movement direction, value doubles as the held-mask bit index
//   kbd_state_t  - prefix-tracking FSM states
//   SC_*         - scancode bytes of interest
//   map_code()   - scancode -> direction lookup (plain vs E0-extended)
//   lowest_set() - priority pick UP > LEFT > DOWN > RIGHT from a held mask
package keyboard_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } kbd_state_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } code_map_t;

    localparam logic [7:0] SC_E0        = 8'hE0;
    localparam logic [7:0] SC_F0        = 8'hF0;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_ESC       = 8'h76;
    localparam logic [7:0] SC_UP        = 8'h1D;
    localparam logic [7:0] SC_LEFT      = 8'h1C;
    localparam logic [7:0] SC_DOWN      = 8'h1B;
    localparam logic [7:0] SC_RIGHT     = 8'h23;
    localparam logic [7:0] SC_EXT_UP    = 8'h75;
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

    function automatic code_map_t map_code(input logic [7:0] code, input logic ext);
        code_map_t m;
        m.valid = 1'b1;
        m.dir   = DIR_UP;
        if (ext) begin
            case (code)
                SC_EXT_UP:    m.dir = DIR_UP;
                SC_EXT_LEFT:  m.dir = DIR_LEFT;
                SC_EXT_DOWN:  m.dir = DIR_DOWN;
                SC_EXT_RIGHT: m.dir = DIR_RIGHT;
                default:      m.valid = 1'b0;
            endcase
        end else begin
            case (code)
                SC_UP:    m.dir = DIR_UP;
                SC_LEFT:  m.dir = DIR_LEFT;
                SC_DOWN:  m.dir = DIR_DOWN;
                SC_RIGHT: m.dir = DIR_RIGHT;
                default:  m.valid = 1'b0;
            endcase
        end
        return m;
    endfunction

    function automatic dir_t lowest_set(input logic [3:0] mask);
        dir_t d;
        d = DIR_UP;
        // Scan high to low so the lowest set index is the last one written.
        for (int unsigned i = 4; i > 0; i--) begin
            if (mask[i-1]) d = dir_t'(2'(i-1));
        end
        return d;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer for an asynchronous level plus a third flop
// for rising-edge detection.
//   clk     - destination clock
//   rst_n   - asynchronous active-low reset
//   i_async - asynchronous input level
//   o_rise  - high for one clk cycle after the synchronized level rises
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/key_direction_mapper.sv
// key_direction_mapper: turns PS/2 set-2 scancode bytes into Pac-ARM commands.
//   clk         - system clock
//   reset       - asynchronous active-low reset
//   word        - scancode byte, stable while read is high
//   read        - byte-ready level, asynchronous to clk
//   held        - held-key mask, bit index = direction code
//   dir         - current direction (0 UP, 1 LEFT, 2 DOWN, 3 RIGHT)
//   dir_valid   - set by the first direction make, cleared only by reset
//   dir_pulse   - one-cycle pulse when dir or dir_valid changes
//   start_pulse - one-cycle pulse on an Enter make
//   pause_pulse - one-cycle pulse on an Esc make
module key_direction_mapper
    import keyboard_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 50000,
    parameter int unsigned TO_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] word,
    input  logic       read,
    output logic [3:0] held,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       dir_pulse,
    output logic       start_pulse,
    output logic       pause_pulse
);

    logic            w_rise;
    logic [7:0]      r_byte;
    logic            r_byte_vld;
    logic [TO_W-1:0] r_to_cnt;

    kbd_state_t      r_state;
    kbd_state_t      w_state_nxt;
    logic [3:0]      r_held;
    logic [3:0]      w_held_nxt;
    dir_t            r_dir;
    dir_t            w_dir_nxt;
    logic            r_dir_valid;
    logic            w_valid_nxt;
    logic            r_dir_pulse;
    logic            w_dir_pulse_nxt;
    logic            r_start_pulse;
    logic            w_start_nxt;
    logic            r_pause_pulse;
    logic            w_pause_nxt;

    logic            w_is_ext;
    logic            w_is_brk;
    code_map_t       w_map;
    logic [3:0]      w_bit;
    logic [3:0]      w_rest;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (reset),
        .i_async (read),
        .o_rise  (w_rise)
    );

    // Capture stage: the byte is latched on the detect cycle and decoded on the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
        end else begin
            r_byte_vld <= w_rise;
            if (w_rise) r_byte <= word;
        end
    end

    // Prefix timeout counter: idles at zero, restarts on every decoded byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_byte_vld || r_state == ST_IDLE) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_W'(PREFIX_TIMEOUT)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_held        <= '0;
            r_dir         <= DIR_UP;
            r_dir_valid   <= 1'b0;
            r_dir_pulse   <= 1'b0;
            r_start_pulse <= 1'b0;
            r_pause_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_held        <= w_held_nxt;
            r_dir         <= w_dir_nxt;
            r_dir_valid   <= w_valid_nxt;
            r_dir_pulse   <= w_dir_pulse_nxt;
            r_start_pulse <= w_start_nxt;
            r_pause_pulse <= w_pause_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_held_nxt      = r_held;
        w_dir_nxt       = r_dir;
        w_valid_nxt     = r_dir_valid;
        w_dir_pulse_nxt = 1'b0;
        w_start_nxt     = 1'b0;
        w_pause_nxt     = 1'b0;

        w_is_ext = (r_state == ST_EXT)   || (r_state == ST_EXT_BREAK);
        w_is_brk = (r_state == ST_BREAK) || (r_state == ST_EXT_BREAK);
        w_map    = map_code(r_byte, w_is_ext);
        w_bit    = 4'(1) << w_map.dir;
        w_rest   = r_held & ~w_bit;

        if (r_byte_vld) begin
            if (r_byte == SC_E0) begin
                w_state_nxt = w_is_brk ? ST_EXT_BREAK : ST_EXT;
            end else if (r_byte == SC_F0) begin
                w_state_nxt = w_is_ext ? ST_EXT_BREAK : ST_BREAK;
            end else begin
                w_state_nxt = ST_IDLE;
                if (w_map.valid) begin
                    if (!w_is_brk) begin
                        w_held_nxt = r_held | w_bit;
                        if (!r_dir_valid || r_dir != w_map.dir) begin
                            w_dir_nxt       = w_map.dir;
                            w_valid_nxt     = 1'b1;
                            w_dir_pulse_nxt = 1'b1;
                        end
                    end else if (r_held[w_map.dir]) begin
                        w_held_nxt = w_rest;
                        // Releasing the active key hands over to the best remaining one;
                        // releasing the last key keeps the old direction.
                        if (w_map.dir == r_dir && w_rest != '0) begin
                            w_dir_nxt       = lowest_set(w_rest);
                            w_dir_pulse_nxt = 1'b1;
                        end
                    end
                end else if (!w_is_ext && !w_is_brk) begin
                    w_start_nxt = (r_byte == SC_ENTER);
                    w_pause_nxt = (r_byte == SC_ESC);
                end
            end
        end else if (r_state != ST_IDLE && r_to_cnt == TO_W'(PREFIX_TIMEOUT)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign held        = r_held;
    assign dir         = r_dir;
    assign dir_valid   = r_dir_valid;
    assign dir_pulse   = r_dir_pulse;
    assign start_pulse = r_start_pulse;
    assign pause_pulse = r_pause_pulse;

endmodule

// File: tb/tb_key_direction_mapper.sv
module tb_key_direction_mapper;

    localparam int unsigned PT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] word = '0;
    logic       read = 1'b0;
    logic [3:0] held;
    logic [1:0] dir;
    logic       dir_valid;
    logic       dir_pulse;
    logic       start_pulse;
    logic       pause_pulse;

    key_direction_mapper #(.PREFIX_TIMEOUT(PT), .TO_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .word        (word),
        .read        (read),
        .held        (held),
        .dir         (dir),
        .dir_valid   (dir_valid),
        .dir_pulse   (dir_pulse),
        .start_pulse (start_pulse),
        .pause_pulse (pause_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Cumulative pulse counts; each byte window looks at the difference.
    int c_dp = 0, c_sp = 0, c_pp = 0;
    always @(negedge clk) begin
        if (dir_pulse)   c_dp <= c_dp + 1;
        if (start_pulse) c_sp <= c_sp + 1;
        if (pause_pulse) c_pp <= c_pp + 1;
    end

    int g_dp, g_sp, g_pp;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One byte handshake: read high 4 cycles, low 3 cycles; reports pulses seen.
    task automatic send_byte(input logic [7:0] b);
        int s_dp, s_sp, s_pp;
        s_dp = c_dp; s_sp = c_sp; s_pp = c_pp;
        @(negedge clk);
        word = b;
        read = 1'b1;
        repeat (4) @(negedge clk);
        read = 1'b0;
        repeat (3) @(negedge clk);
        g_dp = c_dp - s_dp;
        g_sp = c_sp - s_sp;
        g_pp = c_pp - s_pp;
    endtask

    // Reference model, byte-level view.
    logic [3:0] m_held;
    int         m_dir;
    logic       m_valid, m_ext, m_brk;
    int         m_dp, m_sp, m_pp;

    function automatic int dir_of(input logic [7:0] b, input logic ext);
        if (ext) begin
            if (b == 8'h75) return 0;
            if (b == 8'h6B) return 1;
            if (b == 8'h72) return 2;
            if (b == 8'h74) return 3;
        end else begin
            if (b == 8'h1D) return 0;
            if (b == 8'h1C) return 1;
            if (b == 8'h1B) return 2;
            if (b == 8'h23) return 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_held = '0; m_dir = 0; m_valid = 0; m_ext = 0; m_brk = 0;
    endtask

    task automatic model_apply(input logic [7:0] b);
        int k;
        m_dp = 0; m_sp = 0; m_pp = 0;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            k = dir_of(b, m_ext);
            if (k >= 0 && !m_brk) begin
                m_held[k] = 1'b1;
                if (!m_valid || m_dir != k) begin
                    m_dir = k; m_valid = 1; m_dp = 1;
                end
            end else if (k >= 0 && m_held[k]) begin
                m_held[k] = 1'b0;
                if (k == m_dir && m_held != 0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_held[i]) begin m_dir = i; break; end
                    end
                    m_dp = 1;
                end
            end else if (k < 0 && !m_ext && !m_brk) begin
                m_sp = (b == 8'h5A) ? 1 : 0;
                m_pp = (b == 8'h76) ? 1 : 0;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic chk_outputs(input string tag, input int h, input int d, input int v,
                               input int dp, input int sp, input int pp);
        chk({tag, " held"}, held, h);
        chk({tag, " dir"}, dir, d);
        chk({tag, " dir_valid"}, dir_valid, v);
        chk({tag, " dir_pulse"}, g_dp, dp);
        chk({tag, " start_pulse"}, g_sp, sp);
        chk({tag, " pause_pulse"}, g_pp, pp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] b;
        logic [3:0] h;
        logic [1:0] d;
        logic v, dp, sp, pp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] b, input logic [3:0] h, input logic [1:0] d,
                       input logic v, input logic dp, input logic sp, input logic pp);
        vec_t e;
        e.b = b; e.h = h; e.d = d; e.v = v; e.dp = dp; e.sp = sp; e.pp = pp;
        tbl.push_back(e);
    endtask

    initial begin
        logic [7:0] pool [14];
        logic [7:0] b;

        //    byte   held     dir v  dp sp pp
        add(8'h1C, 4'b0010, 1, 1, 1, 0, 0);
        add(8'h1C, 4'b0010, 1, 1, 0, 0, 0);
        add(8'h1B, 4'b0110, 2, 1, 1, 0, 0);
        add(8'hF0, 4'b0110, 2, 1, 0, 0, 0);
        add(8'h1B, 4'b0010, 1, 1, 1, 0, 0);
        add(8'hF0, 4'b0010, 1, 1, 0, 0, 0);
        add(8'h1C, 4'b0000, 1, 1, 0, 0, 0);
        add(8'hE0, 4'b0000, 1, 1, 0, 0, 0);
        add(8'h75, 4'b0001, 0, 1, 1, 0, 0);
        add(8'hE0, 4'b0001, 0, 1, 0, 0, 0);
        add(8'hF0, 4'b0001, 0, 1, 0, 0, 0);
        add(8'h75, 4'b0000, 0, 1, 0, 0, 0);
        add(8'h75, 4'b0000, 0, 1, 0, 0, 0);
        add(8'h5A, 4'b0000, 0, 1, 0, 1, 0);
        add(8'hF0, 4'b0000, 0, 1, 0, 0, 0);
        add(8'h5A, 4'b0000, 0, 1, 0, 0, 0);
        add(8'h76, 4'b0000, 0, 1, 0, 0, 1);
        add(8'hE0, 4'b0000, 0, 1, 0, 0, 0);
        add(8'h5A, 4'b0000, 0, 1, 0, 0, 0);
        add(8'h1D, 4'b0001, 0, 1, 0, 0, 0);
        add(8'h23, 4'b1001, 3, 1, 1, 0, 0);
        add(8'hF0, 4'b1001, 3, 1, 0, 0, 0);
        add(8'h23, 4'b0001, 0, 1, 1, 0, 0);
        add(8'hF0, 4'b0001, 0, 1, 0, 0, 0);
        add(8'h1B, 4'b0001, 0, 1, 0, 0, 0);
        add(8'hE1, 4'b0001, 0, 1, 0, 0, 0);
        add(8'h1C, 4'b0011, 1, 1, 1, 0, 0);

        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        g_dp = 0; g_sp = 0; g_pp = 0;
        chk_outputs("reset", 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            send_byte(tbl[i].b);
            chk_outputs($sformatf("tbl[%0d]", i), tbl[i].h, tbl[i].d, tbl[i].v,
                        tbl[i].dp, tbl[i].sp, tbl[i].pp);
        end

        // Abandoned break prefix: the next 1D is a make.
        do_reset();
        send_byte(8'hF0);
        repeat (PT + 2) @(negedge clk);
        send_byte(8'h1D);
        chk_outputs("timeout", 1, 0, 1, 1, 0, 0);

        // Reset in the middle of an extended prefix.
        do_reset();
        send_byte(8'h1D);
        send_byte(8'hE0);
        do_reset();
        g_dp = 0; g_sp = 0; g_pp = 0;
        chk_outputs("midrst", 0, 0, 0, 0, 0, 0);
        send_byte(8'h6B);
        chk_outputs("midrst 6B", 0, 0, 0, 0, 0, 0);

        // Random byte stream against the model.
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75,
                 8'h6B, 8'h72, 8'h74, 8'h5A, 8'h76, 8'hE1, 8'h00};
        do_reset();
        for (int i = 0; i < 300; i++) begin
            b = pool[$urandom_range(13)];
            if (b == 8'h00) b = 8'($urandom);
            if ($urandom_range(15) == 0) begin
                repeat (PT + 5) @(negedge clk);
                m_ext = 0; m_brk = 0;
            end
            send_byte(b);
            model_apply(b);
            chk_outputs($sformatf("rnd[%0d] %02h", i, b), m_held, m_dir, m_valid,
                        m_dp, m_sp, m_pp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_direction_mapper.md
# key_direction_mapper

Consumes the byte stream produced by `keyboard_decoder` (`word` / `read`) and turns PS/2 set-2 scancodes into game commands for Pac-ARM. It tracks make/break (`F0`) and extended (`E0`) prefixes, keeps a held-key mask for the four directions (WASD and arrow keys), and reports the current movement direction. It also emits one-cycle start and pause pulses. It sits between the PS/2 decoder and the game-logic core, in the system clock domain.

## Interface
Parameters:
- `PREFIX_TIMEOUT`, default 50000: clk cycles a pending prefix state may wait for its next byte before it is abandoned.
- `TO_W`, default 16: width of the timeout counter; must satisfy 2^TO_W > PREFIX_TIMEOUT.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `word` in 8: scancode byte from `keyboard_decoder`. It is held stable while `read` is high.
- `read` in 1: byte-ready level from the decoder, asynchronous to `clk`.
- `held` out 4: held-key mask; bit index is the direction code.
- `dir` out 2: current direction. 0=UP, 1=LEFT, 2=DOWN, 3=RIGHT.
- `dir_valid` out 1: goes high after the first direction make and stays high until reset.
- `dir_pulse` out 1: one-cycle pulse whenever `dir` or `dir_valid` changes.
- `start_pulse` out 1: one-cycle pulse on an Enter make (`5A`).
- `pause_pulse` out 1: one-cycle pulse on an Esc make (`76`).

## Operation
- **Input capture.** `read` passes through a 2-flop synchronizer, then a third flop for rising-edge detect. `word` is captured into `byte_q` on the detect cycle. The decoder must hold `word` for at least 3 clk cycles after `read` rises.
- **FSM states:** IDLE, BREAK, EXT, EXT_BREAK.
  - `E0`: IDLE→EXT, BREAK→EXT_BREAK; EXT and EXT_BREAK stay where they are.
  - `F0`: IDLE→BREAK, EXT→EXT_BREAK; BREAK and EXT_BREAK stay where they are.
  - Any other byte is decoded as make (IDLE/EXT) or break (BREAK/EXT_BREAK), then the FSM returns to IDLE.
  - `E1` and unmapped codes are ignored, then the FSM returns to IDLE.
- **Code map.**
  - Non-extended: `1D`→UP, `1C`→LEFT, `1B`→DOWN, `23`→RIGHT.
  - Extended: `75`→UP, `6B`→LEFT, `72`→DOWN, `74`→RIGHT.
  - `5A` and `76` are recognized only as non-extended makes.
  - In the EXT states, a non-arrow byte is ignored.
- **Make of direction k:**
  - `held[k]<=1`.
  - If `!dir_valid` or `dir!=k`: `dir<=k`, `dir_valid<=1`, `dir_pulse`.
  - A typematic repeat of the current `dir` produces no pulse.
- **Break of direction k:**
  - `held[k]<=0`.
  - If k==`dir` and other bits of `held` remain set: `dir<=` lowest set index (priority UP>LEFT>DOWN>RIGHT), with `dir_pulse`.
  - If no bits remain set: `dir` and `dir_valid` are unchanged (Pac-Man keeps moving).
  - A break of a key that is not held has no effect.
- **Prefix timeout.** A counter runs in every non-IDLE state and reloads on each captured byte. When it reaches PREFIX_TIMEOUT, the FSM goes to IDLE with no output change.

## Timing
- **Reset values:** FSM=IDLE, synchronizer flops 0, `held`=0, `dir`=0, `dir_valid`=0, all pulses 0, counter 0.
- **Latency:** if `read` rises before clk edge n, the outputs update after edge n+3.
  - Edges n and n+1 are the synchronizer.
  - Edge n+2 is the edge detect and capture.
  - Edge n+3 is the decode.
- Pulses are exactly 1 cycle wide and registered.
- **Throughput:** one byte per `read` rising edge. `read` must stay low for at least 2 clk cycles between bytes.
- **Reset mid-sequence:** a pending prefix is discarded and `held` is cleared. After reset deasserts, the first byte is decoded from IDLE.
- A break and a direction change caused by the same byte take effect in the same cycle.

## Structure
- Package `keyboard_pkg` holds:
  - the direction enum `dir_t` (UP/LEFT/DOWN/RIGHT, 2 bits);
  - the FSM state enum;
  - scancode localparams `SC_E0`, `SC_F0`, `SC_ENTER`, `SC_ESC`, and the 8 direction codes.
- One sub-module, `sync_edge`: 2-flop synchronizer plus rising-edge pulse, with asynchronous active-low reset.

## Test plan
- **A make:** send `1C` → 3 cycles later `held`=0010, `dir`=1, `dir_valid`=1, one `dir_pulse`. Send `1C` again → no pulse.
- **Break fallback:** hold A, then make `1B` → `dir`=2, `held`=0110. Send `F0 1B` → `held`=0010, `dir`=1, `dir_pulse`. Send `F0 1C` → `held`=0, `dir` stays 1, no pulse.
- **Extended arrow:** send `E0 75` → `dir`=0. Send `E0 F0 75` → `held`=0. Send a bare `75` → ignored.
- **Prefix timeout:** send `F0`, wait PREFIX_TIMEOUT+2 cycles, send `1D` → treated as a make: `dir`=0, `held`=0001.
- **Start/pause:** send `5A` → one `start_pulse`. Send `F0 5A` → no pulse. Send `76` → one `pause_pulse`.
- **Reset mid-sequence:** send `1D`, then `E0`, pulse `reset` low for 1 cycle, then send `6B` → all outputs were 0 after reset; decoded as unmapped, so outputs stay 0.
